// File: rtl/burst_mem_arbiter_if.sv
// Cache-side pmem ports and the shared 64-bit burst memory port.
// The arbiter uses the slave view; the caches/memory model use the master view.
interface burst_mem_arbiter_if;
    logic [31:0]  icache_pmem_address;
    logic         icache_pmem_read;
    logic [255:0] icache_pmem_rdata;
    logic         icache_pmem_resp;

    logic [31:0]  dcache_pmem_address;
    logic         dcache_pmem_read;
    logic         dcache_pmem_write;
    logic [255:0] dcache_pmem_wdata;
    logic [255:0] dcache_pmem_rdata;
    logic         dcache_pmem_resp;

    logic [31:0]  bmem_address;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_rdata;
    logic [63:0]  bmem_wdata;
    logic         bmem_resp;

    modport slave (
        input  icache_pmem_address, icache_pmem_read,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_address, dcache_pmem_read, dcache_pmem_write, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output bmem_address, bmem_read, bmem_write, bmem_wdata,
        input  bmem_rdata, bmem_resp
    );

    modport master (
        output icache_pmem_address, icache_pmem_read,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_address, dcache_pmem_read, dcache_pmem_write, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  bmem_address, bmem_read, bmem_write, bmem_wdata,
        output bmem_rdata, bmem_resp
    );
endinterface

// File: rtl/burst_mem_arbiter.sv
// Round-robin arbiter between icache and dcache line requests, serializing each
// granted 256-bit line into 64-bit bursts on the bmem port and reassembling reads.
module burst_mem_arbiter #(
    parameter int unsigned BEATS    = 4,
    parameter int unsigned OFFSET_W = 5
) (
    input logic                clk,
    input logic                rst,
    burst_mem_arbiter_if.slave bus
);
    localparam int unsigned CntW  = $clog2(BEATS);
    localparam int unsigned LineW = BEATS * 64;
    localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);

    typedef enum logic [2:0] {StIdle, StIRead, StDRead, StDWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;  // 0: icache, 1: dcache
    logic              grantee_q, grantee_d;
    logic [31:0]       addr_q, addr_d;
    logic [LineW-1:0]  line_q, line_d;
    logic              bmem_read_q, bmem_read_d;
    logic              bmem_write_q, bmem_write_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;
    logic [LineW-1:0]  i_rdata_q, i_rdata_d;
    logic [LineW-1:0]  d_rdata_q, d_rdata_d;

    logic              i_req, d_req, pick_d;
    logic [CntW+5:0]   beat_lsb;

    assign i_req    = bus.icache_pmem_read;
    assign d_req    = bus.dcache_pmem_read | bus.dcache_pmem_write;
    assign beat_lsb = {cnt_q, 6'd0};
    // On a tie the requester not granted last wins.
    assign pick_d   = d_req & (~i_req | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grantee_d    = grantee_q;
        addr_d       = addr_q;
        line_d       = line_q;
        bmem_read_d  = bmem_read_q;
        bmem_write_d = bmem_write_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    cnt_d        = '0;
                    grantee_d    = pick_d;
                    last_grant_d = pick_d;
                    if (pick_d) begin
                        addr_d = {bus.dcache_pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        if (bus.dcache_pmem_write) begin
                            line_d       = bus.dcache_pmem_wdata;
                            bmem_write_d = 1'b1;
                            state_d      = StDWrite;
                        end else begin
                            bmem_read_d = 1'b1;
                            state_d     = StDRead;
                        end
                    end else begin
                        addr_d      = {bus.icache_pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        bmem_read_d = 1'b1;
                        state_d     = StIRead;
                    end
                end
            end
            StIRead, StDRead: begin
                if (bus.bmem_resp) begin
                    line_d[beat_lsb +: 64] = bus.bmem_rdata;
                    cnt_d                  = cnt_q + 1'b1;
                    if (cnt_q == LastBeat) begin
                        bmem_read_d = 1'b0;
                        state_d     = StDone;
                        if (state_q == StIRead) begin
                            i_rdata_d = line_d;
                            i_resp_d  = 1'b1;
                        end else begin
                            d_rdata_d = line_d;
                            d_resp_d  = 1'b1;
                        end
                    end
                end
            end
            StDWrite: begin
                if (bus.bmem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastBeat) begin
                        bmem_write_d = 1'b0;
                        d_resp_d     = 1'b1;
                        state_d      = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= 1'b0;
            grantee_q    <= 1'b0;
            addr_q       <= '0;
            line_q       <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grantee_q    <= grantee_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            bmem_read_q  <= bmem_read_d;
            bmem_write_q <= bmem_write_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.bmem_address      = addr_q;
    assign bus.bmem_read         = bmem_read_q;
    assign bus.bmem_write        = bmem_write_q;
    assign bus.bmem_wdata        = (state_q == StDWrite) ? line_q[beat_lsb +: 64] : 64'd0;
    assign bus.icache_pmem_resp  = i_resp_q;
    assign bus.icache_pmem_rdata = i_rdata_q;
    assign bus.dcache_pmem_resp  = d_resp_q;
    assign bus.dcache_pmem_rdata = d_rdata_q;

    logic unused_bits;
    assign unused_bits = ^{bus.icache_pmem_address[OFFSET_W-1:0],
                           bus.dcache_pmem_address[OFFSET_W-1:0], grantee_q};
endmodule

// File: tb/tb_burst_mem_arbiter.sv
// Directed bench for burst_mem_arbiter: the bench plays both caches and the burst memory.
module tb_burst_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    localparam logic [255:0] LINE_I  = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [255:0] LINE_W  = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    localparam logic [255:0] LINE_D  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                        64'h0F0F_0F0F_F0F0_F0F0, 64'h1357_9BDF_0246_8ACE};
    localparam logic [255:0] LINE_I2 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                                        64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
    localparam logic [255:0] LINE_T  = {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002,
                                        64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000};
    localparam logic [255:0] LINE_T2 = {64'hBEEF_0003_1111_0003, 64'hBEEF_0002_1111_0002,
                                        64'hBEEF_0001_1111_0001, 64'hBEEF_0000_1111_0000};
    localparam logic [255:0] LINE_X  = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                                        64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    localparam logic [255:0] LINE_F  = {64'h0000_0000_F00D_0004, 64'h0000_0000_F00D_0003,
                                        64'h0000_0000_F00D_0002, 64'h0000_0000_F00D_0001};

    burst_mem_arbiter_if bus ();

    burst_mem_arbiter #(
        .BEATS   (4),
        .OFFSET_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first cycle of the burst; leaves in the cycle after the last beat.
    task automatic run_beats(input logic wr, input logic [255:0] line, input int gap,
                             input logic [31:0] addr, input string tag);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                bus.bmem_resp = 1'b0;
                check_eq({tag, " gap read"}, 256'(bus.bmem_read), 256'(!wr));
                check_eq({tag, " gap write"}, 256'(bus.bmem_write), 256'(wr));
                tick();
            end
            bus.bmem_resp  = 1'b1;
            bus.bmem_rdata = wr ? 64'd0 : line[b*64 +: 64];
            check_eq({tag, " read"}, 256'(bus.bmem_read), 256'(!wr));
            check_eq({tag, " write"}, 256'(bus.bmem_write), 256'(wr));
            check_eq({tag, " addr"}, 256'(bus.bmem_address), 256'(addr));
            if (wr) check_eq({tag, " wdata"}, 256'(bus.bmem_wdata), 256'(line[b*64 +: 64]));
            tick();
        end
        bus.bmem_resp  = 1'b0;
        bus.bmem_rdata = 64'd0;
    endtask

    initial begin
        rst                     = 1'b1;
        bus.icache_pmem_address = 32'd0;
        bus.icache_pmem_read    = 1'b0;
        bus.dcache_pmem_address = 32'd0;
        bus.dcache_pmem_read    = 1'b0;
        bus.dcache_pmem_write   = 1'b0;
        bus.dcache_pmem_wdata   = 256'd0;
        bus.bmem_rdata          = 64'd0;
        bus.bmem_resp           = 1'b0;
        tick();
        tick();
        check_eq("rst bmem_read", 256'(bus.bmem_read), 256'd0);
        check_eq("rst bmem_write", 256'(bus.bmem_write), 256'd0);
        check_eq("rst bmem_address", 256'(bus.bmem_address), 256'd0);
        check_eq("rst bmem_wdata", 256'(bus.bmem_wdata), 256'd0);
        check_eq("rst i_resp", 256'(bus.icache_pmem_resp), 256'd0);
        check_eq("rst d_resp", 256'(bus.dcache_pmem_resp), 256'd0);
        check_eq("rst i_rdata", bus.icache_pmem_rdata, 256'd0);
        check_eq("rst d_rdata", bus.dcache_pmem_rdata, 256'd0);
        rst = 1'b0;
        tick();

        // Tie from reset: dcache first, icache one IDLE cycle after dcache resp.
        bus.icache_pmem_address = 32'h0000_1000;
        bus.icache_pmem_read    = 1'b1;
        bus.dcache_pmem_address = 32'h0000_2044;
        bus.dcache_pmem_read    = 1'b1;
        tick();
        run_beats(1'b0, LINE_D, 0, 32'h0000_2040, "tie1 d");
        check_eq("tie1 d_resp", 256'(bus.dcache_pmem_resp), 256'd1);
        check_eq("tie1 i_resp early", 256'(bus.icache_pmem_resp), 256'd0);
        check_eq("tie1 d_rdata", bus.dcache_pmem_rdata, LINE_D);
        check_eq("tie1 read low in done", 256'(bus.bmem_read), 256'd0);
        tick();
        bus.dcache_pmem_read = 1'b0;
        check_eq("tie1 d_resp one cycle", 256'(bus.dcache_pmem_resp), 256'd0);
        check_eq("tie1 idle read", 256'(bus.bmem_read), 256'd0);
        tick();
        run_beats(1'b0, LINE_I2, 1, 32'h0000_1000, "tie1 i");
        check_eq("tie1 i_resp", 256'(bus.icache_pmem_resp), 256'd1);
        check_eq("tie1 i_rdata", bus.icache_pmem_rdata, LINE_I2);
        check_eq("tie1 d_rdata held", bus.dcache_pmem_rdata, LINE_D);
        tick();
        bus.icache_pmem_read = 1'b0;
        tick();

        // Icache fill: address 0x64 aligns to 0x60, resp in cycle 5.
        bus.icache_pmem_address = 32'h0000_0064;
        bus.icache_pmem_read    = 1'b1;
        tick();
        run_beats(1'b0, LINE_I, 0, 32'h0000_0060, "ifill");
        check_eq("ifill i_resp", 256'(bus.icache_pmem_resp), 256'd1);
        check_eq("ifill i_rdata", bus.icache_pmem_rdata, LINE_I);
        check_eq("ifill read low", 256'(bus.bmem_read), 256'd0);
        tick();
        bus.icache_pmem_read = 1'b0;
        check_eq("ifill i_resp one cycle", 256'(bus.icache_pmem_resp), 256'd0);
        tick();

        // Dcache writeback with 2-cycle gaps.
        bus.dcache_pmem_address = 32'h8000_01E0;
        bus.dcache_pmem_wdata   = LINE_W;
        bus.dcache_pmem_write   = 1'b1;
        tick();
        run_beats(1'b1, LINE_W, 2, 32'h8000_01E0, "wb");
        check_eq("wb d_resp", 256'(bus.dcache_pmem_resp), 256'd1);
        check_eq("wb write low", 256'(bus.bmem_write), 256'd0);
        check_eq("wb d_rdata held", bus.dcache_pmem_rdata, LINE_D);
        tick();
        bus.dcache_pmem_write = 1'b0;
        tick();

        // Tie after a dcache grant: icache first.
        bus.icache_pmem_address = 32'h0000_3000;
        bus.icache_pmem_read    = 1'b1;
        bus.dcache_pmem_address = 32'h0000_401F;
        bus.dcache_pmem_read    = 1'b1;
        tick();
        run_beats(1'b0, LINE_T, 0, 32'h0000_3000, "tie2 i");
        check_eq("tie2 i_resp", 256'(bus.icache_pmem_resp), 256'd1);
        check_eq("tie2 d_resp early", 256'(bus.dcache_pmem_resp), 256'd0);
        check_eq("tie2 i_rdata", bus.icache_pmem_rdata, LINE_T);
        tick();
        bus.icache_pmem_read = 1'b0;
        tick();
        run_beats(1'b0, LINE_T2, 0, 32'h0000_4000, "tie2 d");
        check_eq("tie2 d_resp", 256'(bus.dcache_pmem_resp), 256'd1);
        check_eq("tie2 d_rdata", bus.dcache_pmem_rdata, LINE_T2);
        tick();
        bus.dcache_pmem_read = 1'b0;
        tick();

        // Read and write both high: write wins.
        bus.dcache_pmem_address = 32'h0000_5008;
        bus.dcache_pmem_wdata   = LINE_X;
        bus.dcache_pmem_read    = 1'b1;
        bus.dcache_pmem_write   = 1'b1;
        tick();
        run_beats(1'b1, LINE_X, 0, 32'h0000_5000, "rw");
        check_eq("rw d_resp", 256'(bus.dcache_pmem_resp), 256'd1);
        tick();
        bus.dcache_pmem_read  = 1'b0;
        bus.dcache_pmem_write = 1'b0;
        tick();

        // Reset after beat 1 of an icache read.
        bus.icache_pmem_address = 32'h0000_6020;
        bus.icache_pmem_read    = 1'b1;
        tick();
        bus.bmem_resp  = 1'b1;
        bus.bmem_rdata = 64'hAAAA_0000_0000_0000;
        tick();
        bus.bmem_rdata = 64'hAAAA_0000_0000_0001;
        tick();
        bus.bmem_resp        = 1'b0;
        bus.icache_pmem_read = 1'b0;
        rst                  = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid rst read", 256'(bus.bmem_read), 256'd0);
        check_eq("mid rst addr", 256'(bus.bmem_address), 256'd0);
        check_eq("mid rst i_rdata", bus.icache_pmem_rdata, 256'd0);
        for (int c = 0; c < 3; c++) begin
            check_eq("mid rst i_resp", 256'(bus.icache_pmem_resp), 256'd0);
            tick();
        end

        // Stray bmem_resp pulses in IDLE are ignored.
        bus.bmem_resp  = 1'b1;
        bus.bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("idle read", 256'(bus.bmem_read), 256'd0);
            check_eq("idle write", 256'(bus.bmem_write), 256'd0);
            check_eq("idle resp", 256'({bus.icache_pmem_resp, bus.dcache_pmem_resp}), 256'd0);
        end
        bus.bmem_resp  = 1'b0;
        bus.bmem_rdata = 64'd0;
        check_eq("idle i_rdata", bus.icache_pmem_rdata, 256'd0);
        check_eq("idle d_rdata", bus.dcache_pmem_rdata, 256'd0);

        // Normal fill after the reset and stray pulses.
        bus.icache_pmem_address = 32'h0000_7FFF;
        bus.icache_pmem_read    = 1'b1;
        tick();
        run_beats(1'b0, LINE_F, 0, 32'h0000_7FE0, "post");
        check_eq("post i_resp", 256'(bus.icache_pmem_resp), 256'd1);
        check_eq("post i_rdata", bus.icache_pmem_rdata, LINE_F);
        tick();
        bus.icache_pmem_read = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
